// File: rtl/ascon_params.sv
// Shared constants and types for the ASCON state-register control path.
// WORD_SIZE/PAR/D are the default datapath geometry; N1/ND are the serial
// beats per pass for the unmasked and masked shift widths, and CNT_W is the
// width of a beat index.
package ascon_params;

  localparam int unsigned WORD_SIZE          = 64;
  localparam int unsigned PAR                = 5;
  localparam int unsigned D                  = 1;
  localparam int unsigned SHIFT_PAR          = PAR;
  localparam int unsigned SHIFT_PAR_D_PLUS_1 = (D + 1) * PAR;

  // Beats needed to move `word` bits at `bits` per beat. Never below 1.
  function automatic int unsigned ceil_div(int unsigned word, int unsigned bits);
    int unsigned n;
    n = (word + bits - 1) / bits;
    return (n < 1) ? 1 : n;
  endfunction

  // Index width able to address every beat of the longer pass. Never below 1.
  function automatic int unsigned cnt_width(int unsigned n1, int unsigned nd);
    int unsigned m;
    m = (n1 > nd) ? n1 : nd;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  localparam int unsigned N1    = ceil_div(WORD_SIZE, SHIFT_PAR);
  localparam int unsigned ND    = ceil_div(WORD_SIZE, SHIFT_PAR_D_PLUS_1);
  localparam int unsigned CNT_W = cnt_width(N1, ND);

  typedef enum logic [1:0] {
    OpLoad  = 2'b00,
    OpPass1 = 2'b01,
    OpPassD = 2'b10,
    OpRound = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftD,
    StShift1,
    StDone
  } state_e;

endpackage

// File: rtl/beat_counter.sv
// Beat counter for one serial pass.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear to 0 (wins over en)
//   en           : advance one beat; wraps to 0 after reaching limit
//   limit        : index of the final beat of the current pass
//   count        : current beat index
//   tc           : count == limit (terminal beat)
module beat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc    = (count_q == limit);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/state_shift_sequencer.sv
// Control sequencer for the ASCON state register. Accepts LOAD / PASS_1 /
// PASS_D / ROUND commands over a valid/ready handshake and produces the
// register strobes, counting serial beats so each word shifts through once per
// pass. Completion is flagged by a one-cycle done pulse.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_op, cmd_rounds    : command and repeat count, latched at acceptance
//   stall                 : freeze the current beat
//   abort                 : synchronous cancel back to IDLE, no done
//   write_en, shift_en    : parallel-load and shift strobes
//   shift_type            : 1 = PAR-bit shift, 0 = (D+1)*PAR-bit shift
//   last_cycle            : current beat is the last of the pass
//   beat_idx, round_idx   : position within the pass / repetition
//   busy, done            : activity flag, completion pulse
module state_shift_sequencer #(
  parameter int unsigned WORD_SIZE  = ascon_params::WORD_SIZE,
  parameter int unsigned PAR        = ascon_params::PAR,
  parameter int unsigned D          = ascon_params::D,
  parameter int unsigned RND_W      = 4,
  localparam int unsigned N1        = ascon_params::ceil_div(WORD_SIZE, PAR),
  localparam int unsigned ND        = ascon_params::ceil_div(WORD_SIZE, (D + 1) * PAR),
  localparam int unsigned CNT_W     = ascon_params::cnt_width(N1, ND)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RND_W-1:0] cmd_rounds,
  input  logic             stall,
  input  logic             abort,
  output logic             write_en,
  output logic             shift_en,
  output logic             shift_type,
  output logic             last_cycle,
  output logic [CNT_W-1:0] beat_idx,
  output logic [RND_W-1:0] round_idx,
  output logic             busy,
  output logic             done
);

  import ascon_params::*;

  localparam logic [CNT_W-1:0] LastBeat1 = CNT_W'(N1 - 1);
  localparam logic [CNT_W-1:0] LastBeatD = CNT_W'(ND - 1);

  state_e           state_q, state_d;
  cmd_op_e          op_q, op_d;
  logic [RND_W-1:0] rounds_q, rounds_d;
  logic [RND_W-1:0] round_q, round_d;

  logic             in_shift;
  logic             beat_adv;
  logic             beat_tc;
  logic             pass_end;
  logic             last_round;
  logic [CNT_W-1:0] beat_limit;
  logic [CNT_W-1:0] beat_cnt;

  assign in_shift   = (state_q == StShiftD) || (state_q == StShift1);
  assign beat_adv   = in_shift && !stall && !abort;
  assign pass_end   = beat_adv && beat_tc;
  assign last_round = (round_q == rounds_q - RND_W'(1));
  assign beat_limit = (state_q == StShift1) ? LastBeat1 : LastBeatD;

  // The counter wraps to 0 on the terminal beat, so it is already at 0 when
  // the next pass (or DONE) begins; only abort needs an explicit clear.
  beat_counter #(
    .CNT_W(CNT_W)
  ) u_beat_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (abort),
    .en     (beat_adv),
    .limit  (beat_limit),
    .count  (beat_cnt),
    .tc     (beat_tc)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rounds_d = rounds_q;
    round_d  = round_q;
    if (abort) begin
      state_d = StIdle;
      round_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_d     = cmd_op_e'(cmd_op);
            rounds_d = cmd_rounds;
            round_d  = '0;
            if (cmd_op_e'(cmd_op) == OpLoad) begin
              state_d = StLoad;
            end else if (cmd_rounds == '0) begin
              state_d = StDone;
            end else if (cmd_op_e'(cmd_op) == OpPass1) begin
              state_d = StShift1;
            end else begin
              state_d = StShiftD;
            end
          end
        end
        StLoad: state_d = StDone;
        StShiftD: begin
          if (pass_end) begin
            if (op_q == OpRound) begin
              // Masked half of a round: continue with the unmasked half.
              state_d = StShift1;
            end else if (last_round) begin
              state_d = StDone;
              round_d = '0;
            end else begin
              round_d = round_q + RND_W'(1);
            end
          end
        end
        StShift1: begin
          if (pass_end) begin
            if (last_round) begin
              state_d = StDone;
              round_d = '0;
            end else begin
              round_d = round_q + RND_W'(1);
              if (op_q == OpRound) begin
                state_d = StShiftD;
              end
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= OpLoad;
      rounds_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rounds_q <= rounds_d;
      round_q  <= round_d;
    end
  end

  // Strobes are suppressed during an abort cycle; everything else follows
  // the registered state and counters.
  always_comb begin
    cmd_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle) && (state_q != StDone);
    write_en   = (state_q == StLoad) && !abort;
    shift_en   = beat_adv;
    shift_type = (state_q == StShift1);
    last_cycle = in_shift && beat_tc;
    beat_idx   = beat_cnt;
    round_idx  = round_q;
    done       = (state_q == StDone) && !abort;
  end

endmodule
